// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and defaults
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_e;
  localparam int DEFAULT_CLKS_PER_BIT = 2604;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign count = wr_q - rd_q;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = wr_q == rd_q;
  assign rdata = mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: buffered UART transmitter with configurable frame format
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  tx_state_e state_q, state_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, rdata;
  logic stop_idx_q, stop_idx_d, par_q, par_d, tx_q, tx_d;
  logic pop, full, empty, tick, last_stop;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(in_valid && !full), .pop(pop), .wdata(in_data),
    .rdata(rdata), .full(full), .empty(empty), .count(fifo_count)
  );
  assign in_ready = !full;
  assign busy = state_q != IDLE || !empty;
  assign tx = tx_q;
  assign tick = baud_cnt_q == BW'(CLKS_PER_BIT - 1);
  assign last_stop = tick && (STOP_BITS == 1 || stop_idx_q);
  always_comb begin
    state_d = state_q;
    bit_idx_d = bit_idx_q;
    stop_idx_d = stop_idx_q;
    sh_d = sh_q;
    par_d = par_q;
    pop = 1'b0;
    baud_cnt_d = (state_q == IDLE || tick) ? '0 : baud_cnt_q + 1'b1;
    // tx follows the state one cycle late so the line is glitch-free from a flop
    tx_d = state_q == START ? 1'b0 :
           state_q == DATA  ? sh_q[0] :
           state_q == PAR   ? (PARITY == PAR_EVEN ? par_q : ~par_q) : 1'b1;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        sh_d = rdata;
        par_d = ^rdata;
        state_d = START;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_idx_d = '0;
      end
      DATA: if (tick) begin
        sh_d = sh_q >> 1;
        bit_idx_d = bit_idx_q + 1'b1;
        stop_idx_d = 1'b0;
        if (bit_idx_q == IW'(DATA_BITS - 1)) state_d = PARITY == PAR_NONE ? STOP : PAR;
      end
      PAR: if (tick) begin
        state_d = STOP;
        stop_idx_d = 1'b0;
      end
      STOP: if (tick) begin
        stop_idx_d = 1'b1;
        if (last_stop) begin
          // chain straight into the next start bit when data is waiting
          pop = !empty;
          sh_d = empty ? sh_q : rdata;
          par_d = empty ? par_q : ^rdata;
          state_d = empty ? IDLE : START;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q <= '0;
      stop_idx_q <= 1'b0;
      sh_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      sh_q <= sh_d;
      par_q <= par_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: four frame formats driven with random bytes against a bit-level frame model
module tb_uart_tx_stream;
  import uart_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v[4];
  logic [7:0] d[4];
  logic tx_w[4], busy_w[4], rdy_w[4];
  logic [2:0] cnt_w[4];
  logic exp_q[$];
  int total = 0;
  int bad = 0;
  bit saw_full;
  always #5 clk = ~clk;
  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .reset(reset), .in_valid(v[0]), .in_ready(rdy_w[0]), .in_data(d[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));
  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .reset(reset), .in_valid(v[1]), .in_ready(rdy_w[1]), .in_data(d[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));
  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .reset(reset), .in_valid(v[2]), .in_ready(rdy_w[2]), .in_data(d[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));
  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
    .clk(clk), .reset(reset), .in_valid(v[3]), .in_ready(rdy_w[3]), .in_data(d[3][6:0]),
    .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));
  // expected line level per clock: start, LSB-first data, optional parity, stop bits
  function automatic void add_frame(input int k, input logic [7:0] b);
    logic fb[$];
    int nb = (k == 3) ? 7 : 8;
    int st = (k == 3) ? 2 : 1;
    int ones = 0;
    fb.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      fb.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (k == 1 || k == 3) fb.push_back(ones % 2 == 1);
    if (k == 2) fb.push_back(ones % 2 == 0);
    repeat (st) fb.push_back(1'b1);
    foreach (fb[i]) repeat (4) exp_q.push_back(fb[i]);
  endfunction
  task automatic push(input int k, input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    while (rdy_w[k] !== 1'b1 && w < 200) begin
      saw_full = 1'b1;
      total++;
      assert (cnt_w[k] === 3'd4) else begin bad++; $error("FAIL ready_vs_count k=%0d count=%0d required=4 while in_ready=0", k, cnt_w[k]); end
      @(negedge clk);
      w++;
    end
    total++;
    assert (w < 200) else begin bad++; $error("FAIL push_wait k=%0d waited=%0d required<200", k, w); end
    v[k] = 1'b1;
    d[k] = b;
    add_frame(k, b);
    @(posedge clk);
  endtask
  task automatic release_in(input int k);
    @(negedge clk);
    v[k] = 1'b0;
  endtask
  task automatic send(input int k, input logic [7:0] b);
    push(k, b);
    release_in(k);
  endtask
  task automatic check_stream(input int k, input int ncyc, input string tag);
    int w = 0;
    logic e;
    @(negedge clk);
    while (tx_w[k] !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    total++;
    assert (w < 50) else begin bad++; $error("FAIL %s start_timeout waited=%0d required<50", tag, w); end
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 1'bx;
      total++;
      assert (tx_w[k] === e) else begin bad++; $error("FAIL %s cycle=%0d tx=%b required=%b", tag, i, tx_w[k], e); end
    end
    @(negedge clk);
    total++;
    assert (tx_w[k] === 1'b1 && busy_w[k] === 1'b0 && exp_q.size() == 0)
      else begin bad++; $error("FAIL %s end tx=%b busy=%b left=%0d required tx=1 busy=0 left=0", tag, tx_w[k], busy_w[k], exp_q.size()); end
  endtask
  task automatic check_idle(input int k, input string tag);
    total++;
    assert (tx_w[k] === 1'b1 && rdy_w[k] === 1'b1 && busy_w[k] === 1'b0 && cnt_w[k] === 3'd0)
      else begin bad++; $error("FAIL %s tx=%b rdy=%b busy=%b cnt=%0d required 1 1 0 0", tag, tx_w[k], rdy_w[k], busy_w[k], cnt_w[k]); end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] r0, r1, r2;
    for (int k = 0; k < 4; k++) begin v[k] = 1'b0; d[k] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) check_idle(k, "reset_state");
    fork send(0, 8'h41); check_stream(0, 40, "8n1_41"); join
    r0 = 8'($urandom);
    fork send(0, r0); check_stream(0, 40, "8n1_rand"); join
    fork send(1, 8'h41); check_stream(1, 44, "8e1_41"); join
    fork send(2, 8'h41); check_stream(2, 44, "8o1_41"); join
    r0 = 8'($urandom);
    fork send(1, r0); check_stream(1, 44, "8e1_rand"); join
    r0 = 8'($urandom);
    fork send(2, r0); check_stream(2, 44, "8o1_rand"); join
    fork send(3, 8'h55); check_stream(3, 44, "7e2_55"); join
    r0 = {1'b0, 7'($urandom)};
    fork send(3, r0); check_stream(3, 44, "7e2_rand"); join
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(0, 8'h41 + 8'(i));
        release_in(0);
        total++;
        assert (saw_full) else begin bad++; $error("FAIL backpressure in_ready=1 throughout required a low phase"); end
      end
      check_stream(0, 240, "stream");
    join
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    fork
      begin
        push(0, r0);
        push(0, r1);
        release_in(0);
        repeat (39) @(negedge clk);
        total++;
        assert (cnt_w[0] === 3'd1) else begin bad++; $error("FAIL pushpop_before count=%0d required=1", cnt_w[0]); end
        v[0] = 1'b1;
        d[0] = r2;
        add_frame(0, r2);
        @(negedge clk);
        v[0] = 1'b0;
        total++;
        assert (cnt_w[0] === 3'd1) else begin bad++; $error("FAIL pushpop_after count=%0d required=1", cnt_w[0]); end
      end
      check_stream(0, 120, "pushpop");
    join
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    push(0, r0);
    push(0, r1);
    push(0, r2);
    release_in(0);
    repeat (13) @(negedge clk);
    total++;
    assert (cnt_w[0] === 3'd2 && busy_w[0] === 1'b1 && tx_w[0] === r0[2])
      else begin bad++; $error("FAIL midframe cnt=%0d busy=%b tx=%b required 2 1 %b", cnt_w[0], busy_w[0], tx_w[0], r0[2]); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check_idle(0, "after_reset");
    fork send(0, 8'h5A); check_stream(0, 40, "post_reset_5a"); join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised, buffered UART transmitter that replaces the fixed-pattern demo transmitter. It accepts bytes from on-chip logic over a valid/ready stream into a small FIFO and serialises them onto the FTDI TX line. Data width, parity, stop bits, baud divisor and buffer depth are configurable, and frames stream back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, 2604: clock cycles per bit period (25 MHz / 9600 baud). Must be ≥ 2.
- `DATA_BITS`, 8: payload bits per frame, range 5–9.
- `PARITY`, `PAR_NONE`: parity mode, one of `PAR_NONE`, `PAR_ODD` or `PAR_EVEN` (`uart_pkg::parity_e`).
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, 16: buffer entries. Must be a power of 2, ≥ 2.
- `clk` in 1: system clock (`clk_25mhz` at top level).
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: buffer can accept. Equals !full.
- `in_data` in `DATA_BITS`: payload, sent LSB first.
- `tx` out 1: serial line. Registered output, idles high.
- `busy` out 1: a frame is in progress, or the FIFO is non-empty.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.

## Operation
- A push occurs on a clock edge where `in_valid && in_ready`. `in_data` is written to the FIFO tail.
- FSM states: `IDLE`, `START`, `DATA`, `PAR`, `STOP`.
  - `IDLE`: `tx`=1. If the FIFO is non-empty, pop into shift register `sh`, load parity accumulator, clear `baud_cnt`, go to `START`.
  - `START`: `tx`=0 for one bit period, then go to `DATA` with `bit_idx`=0.
  - `DATA`: `tx`=`sh[0]`. At each bit tick, shift `sh` right and increment `bit_idx`. On the tick at `bit_idx`==`DATA_BITS`-1, go to `PAR` if `PARITY`≠`PAR_NONE`, else go to `STOP`.
  - `PAR`: `tx`=^data for `PAR_EVEN`, ~^data for `PAR_ODD`, held for one bit period. Then go to `STOP` with `stop_idx`=0.
  - `STOP`: `tx`=1 for `STOP_BITS` bit periods. On the final tick:
    - FIFO non-empty: pop and go directly to `START` (zero idle gap).
    - FIFO empty: go to `IDLE`.
- Bit tick: `baud_cnt`==`CLKS_PER_BIT`-1. `baud_cnt` wraps to 0 on the tick. `baud_cnt` is held at 0 in `IDLE`, so the counter is frame-aligned rather than free-running.
- Width: `baud_cnt` is `$clog2(CLKS_PER_BIT)` bits. `bit_idx` is `$clog2(DATA_BITS)` bits. FIFO pointers carry one extra wrap bit to distinguish full from empty.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged. A push while full is impossible because `in_ready`=0.
- `in_data` is captured at push. Later changes to `in_data` do not affect queued data.

## Timing
- Reset values: `tx`=1, `in_ready`=1, `busy`=0, `fifo_count`=0, FSM=`IDLE`, FIFO empty.
- Reset mid-frame aborts the frame. `tx`=1 from the cycle after the reset edge, and FIFO contents are discarded.
- Latency from an empty, idle state, with the push at edge E:
  - FIFO non-empty after E.
  - Pop and transition to `START` at E+1.
  - `tx` goes low after E+2.
- Every bit, including start, parity and stop bits, lasts exactly `CLKS_PER_BIT` cycles.
- Frame length = `CLKS_PER_BIT`·(1 + `DATA_BITS` + (`PARITY`≠`PAR_NONE`) + `STOP_BITS`).
- `in_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the pop that frees an entry.

## Structure
- `uart_pkg`:
  - `parity_e` enum (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`).
  - `tx_state_e` enum.
  - `DEFAULT_CLKS_PER_BIT` = 2604.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`): push/pop, full, empty, count, synchronous reset. It is reusable by a future `uart_rx_stream`.
- FSM, baud counter and shift register live in `uart_tx_stream`.

## Test plan
Bench parameters: `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.

- **Single byte, 8N1:** push 8'h41 → `tx` low for 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then high for 4 cycles. Frame is 40 cycles, `busy`=0 afterwards.
- **Parity:** push 8'h41 with `PAR_EVEN` → parity bit 0. With `PAR_ODD` → parity bit 1. Frame is 44 cycles.
- **Streaming and backpressure:** hold `in_valid`=1 with data 8'h41..8'h46 → `in_ready` drops once `fifo_count`=4. All six frames appear in order, back-to-back, with no idle cycle between stop and start: 240 cycles total from the first start edge.
- **7E2 format:** `DATA_BITS`=7, `STOP_BITS`=2, `PAR_EVEN`, push 7'h55 → 11 bit periods (44 cycles), parity bit 0, two high stop bits.
- **Reset mid-frame:** assert `reset` during the 3rd data bit with 2 bytes queued → after the next cycle `tx`=1, `busy`=0, `fifo_count`=0, `in_ready`=1. A new push of 8'h5A is transmitted correctly.
- **Simultaneous push/pop:** push exactly on the stop-bit tick while 1 entry is queued → `fifo_count` stays 1 across that edge and both bytes are sent in order.
